// File: rtl/multicycle_pc_sequencer_if.sv
// rtl/multicycle_pc_sequencer_if.sv - IFU and LSU request/response handshake bundle for the PC sequencer
interface multicycle_pc_sequencer_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            ifu_req_valid;
    logic [XLEN-1:0] ifu_req_addr;
    logic            ifu_req_ready;
    logic            ifu_rsp_valid;
    logic [ILEN-1:0] ifu_rsp_inst;
    logic            ifu_rsp_err;
    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic            lsu_rsp_valid;

    modport master (
        output ifu_req_valid,
        output ifu_req_addr,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  ifu_rsp_inst,
        input  ifu_rsp_err,
        output lsu_req_valid,
        input  lsu_req_ready,
        input  lsu_rsp_valid
    );

    modport slave (
        input  ifu_req_valid,
        input  ifu_req_addr,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output ifu_rsp_inst,
        output ifu_rsp_err,
        input  lsu_req_valid,
        output lsu_req_ready,
        output lsu_rsp_valid
    );
endinterface

// File: rtl/multicycle_pc_sequencer.sv
// rtl/multicycle_pc_sequencer.sv - multi-cycle fetch/exec/mem/writeback sequencer owning the PC
module multicycle_pc_sequencer #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_pc_sequencer_if.master bus,
    output logic [ILEN-1:0]      inst,
    output logic [XLEN-1:0]      pc,
    input  logic                 exu_is_mem,
    input  logic                 exu_rd_wen,
    input  logic                 exu_jump,
    input  logic [XLEN-1:0]      exu_target,
    input  logic                 exu_halt,
    output logic                 gpr_wen,
    output logic                 retire,
    output logic                 halted,
    output logic                 trap,
    output logic [1:0]           trap_cause
);
    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_EXEC,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WB,
        S_HALT,
        S_TRAP
    } state_t;

    state_t          state;
    logic            ifu_req_q;
    logic            lsu_req_q;
    logic            rd_wen_q;
    logic            jump_q;
    logic [XLEN-1:0] target_q;

    assign bus.ifu_req_valid = ifu_req_q;
    assign bus.ifu_req_addr  = pc;
    assign bus.lsu_req_valid = lsu_req_q;

    // Request valids, gpr_wen and retire are registered so each is set on the
    // edge entering the state that owns it; pulses clear by default every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_RESET;
            pc         <= RESET_PC;
            inst       <= '0;
            ifu_req_q  <= 1'b0;
            lsu_req_q  <= 1'b0;
            rd_wen_q   <= 1'b0;
            jump_q     <= 1'b0;
            target_q   <= '0;
            gpr_wen    <= 1'b0;
            retire     <= 1'b0;
            halted     <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= 2'd0;
        end else begin
            gpr_wen <= 1'b0;
            retire  <= 1'b0;
            unique case (state)
                S_RESET: begin
                    ifu_req_q <= 1'b1;
                    state     <= S_FETCH_REQ;
                end
                S_FETCH_REQ: begin
                    if (bus.ifu_req_ready) begin
                        ifu_req_q <= 1'b0;
                        state     <= S_FETCH_WAIT;
                    end
                end
                S_FETCH_WAIT: begin
                    // A bus error takes priority over any instruction data on the same beat.
                    if (bus.ifu_rsp_valid) begin
                        if (bus.ifu_rsp_err) begin
                            trap       <= 1'b1;
                            trap_cause <= 2'd2;
                            state      <= S_TRAP;
                        end else begin
                            inst  <= bus.ifu_rsp_inst;
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    rd_wen_q <= exu_rd_wen;
                    jump_q   <= exu_jump;
                    target_q <= exu_target;
                    if (exu_halt) begin
                        retire <= 1'b1;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (exu_jump && (exu_target[1:0] != 2'b00)) begin
                        trap       <= 1'b1;
                        trap_cause <= 2'd1;
                        state      <= S_TRAP;
                    end else if (exu_is_mem) begin
                        lsu_req_q <= 1'b1;
                        state     <= S_MEM_REQ;
                    end else begin
                        gpr_wen <= exu_rd_wen;
                        retire  <= 1'b1;
                        state   <= S_WB;
                    end
                end
                S_MEM_REQ: begin
                    if (bus.lsu_req_ready) begin
                        lsu_req_q <= 1'b0;
                        state     <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (bus.lsu_rsp_valid) begin
                        gpr_wen <= rd_wen_q;
                        retire  <= 1'b1;
                        state   <= S_WB;
                    end
                end
                S_WB: begin
                    pc        <= jump_q ? target_q : pc + XLEN'(4);
                    ifu_req_q <= 1'b1;
                    state     <= S_FETCH_REQ;
                end
                S_HALT, S_TRAP: begin
                    state <= state;
                end
                default: begin
                    state <= S_TRAP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_pc_sequencer.sv
// tb/tb_multicycle_pc_sequencer.sv - scoreboard bench for the multi-cycle PC sequencer
module tb_multicycle_pc_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst64 = 1'b0;
    always #5 clk = ~clk;

    multicycle_pc_sequencer_if #(.XLEN(32), .ILEN(32)) bus ();
    multicycle_pc_sequencer_if #(.XLEN(64), .ILEN(32)) bus64 ();

    logic [31:0] inst, pc;
    logic        gpr_wen, retire, halted, trap;
    logic [1:0]  trap_cause;
    logic        cur_mem = 1'b0, cur_rdw = 1'b0, cur_jmp = 1'b0, cur_hlt = 1'b0;
    logic [31:0] cur_tgt = '0;

    logic [31:0] inst64;
    logic [63:0] pc64;
    logic        gpr_wen64, retire64, halted64, trap64;
    logic [1:0]  trap_cause64;

    multicycle_pc_sequencer #(.XLEN(32), .ILEN(32), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst), .bus(bus), .inst(inst), .pc(pc),
        .exu_is_mem(cur_mem), .exu_rd_wen(cur_rdw), .exu_jump(cur_jmp),
        .exu_target(cur_tgt), .exu_halt(cur_hlt),
        .gpr_wen(gpr_wen), .retire(retire), .halted(halted), .trap(trap), .trap_cause(trap_cause)
    );

    multicycle_pc_sequencer #(.XLEN(64), .ILEN(32), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut64 (
        .clk(clk), .rst(rst64), .bus(bus64), .inst(inst64), .pc(pc64),
        .exu_is_mem(1'b0), .exu_rd_wen(1'b1), .exu_jump(1'b0),
        .exu_target(64'd0), .exu_halt(1'b0),
        .gpr_wen(gpr_wen64), .retire(retire64), .halted(halted64), .trap(trap64), .trap_cause(trap_cause64)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        gw;
        logic [31:0] pc;
        int          off;
    } ret_t;

    logic [31:0] exp_fetch[$];
    ret_t        exp_ret[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit after each falling edge, pops expectations on
    // every fetch transfer and every retire pulse.
    int   cyc = 0;
    int   start_cyc = 0;
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        logic [31:0] ea;
        ret_t        er;
        #1;
        cyc++;
        if (bus.ifu_req_valid && !prev_v) start_cyc = cyc;
        prev_v = bus.ifu_req_valid;
        if (bus.ifu_req_valid && bus.ifu_req_ready) begin
            if (exp_fetch.size() == 0) begin
                checks++; errors++;
                $display("FAIL fetch_unexpected: actual=%h required=no transfer", bus.ifu_req_addr);
            end else begin
                ea = exp_fetch.pop_front();
                check("fetch_addr", bus.ifu_req_addr, ea);
            end
        end
        if (retire) begin
            if (exp_ret.size() == 0) begin
                checks++; errors++;
                $display("FAIL retire_unexpected: actual pc=%h required=no retire", pc);
            end else begin
                er = exp_ret.pop_front();
                check("retire_gpr_wen", gpr_wen, er.gw);
                check("retire_pc", pc, er.pc);
                check("retire_latency", cyc - start_cyc, er.off);
            end
        end else if (gpr_wen) begin
            checks++; errors++;
            $display("FAIL gpr_wen_orphan: actual gpr_wen=1 required=0 (pc=%h)", pc);
        end
    end

    task automatic clear_inputs();
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        bus.ifu_rsp_inst  = '0;
        bus.ifu_rsp_err   = 1'b0;
        bus.lsu_req_ready = 1'b0;
        bus.lsu_rsp_valid = 1'b0;
        {cur_mem, cur_rdw, cur_jmp, cur_hlt} = 4'b0;
        cur_tgt = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ifu_valid();
        int n = 0;
        while (!bus.ifu_req_valid && n < 50) begin @(negedge clk); n++; end
        if (!bus.ifu_req_valid) begin
            checks++; errors++;
            $display("FAIL ifu_req_timeout: actual=0 required=1");
        end
    endtask

    task automatic wait_lsu_valid();
        int n = 0;
        while (!bus.lsu_req_valid && n < 50) begin @(negedge clk); n++; end
        if (!bus.lsu_req_valid) begin
            checks++; errors++;
            $display("FAIL lsu_req_timeout: actual=0 required=1");
        end
    endtask

    // Drives one instruction through fetch, exec and optional memory; returns in
    // the cycle after EXEC (WB/HALT/TRAP) or in WB for memory instructions.
    task automatic run_inst(input logic [31:0] addr, input logic m, input logic rdw,
                            input logic jmp, input logic hlt, input logic [31:0] tgt,
                            input int rdy_dly, input int lsu_dly, input int off,
                            input bit expect_retire);
        ret_t r;
        exp_fetch.push_back(addr);
        if (expect_retire) begin
            r.gw = hlt ? 1'b0 : rdw;
            r.pc = addr;
            r.off = off;
            exp_ret.push_back(r);
        end
        {cur_mem, cur_rdw, cur_jmp, cur_hlt} = {m, rdw, jmp, hlt};
        cur_tgt = tgt;
        wait_ifu_valid();
        for (int i = 0; i < rdy_dly; i++) begin
            check("req_hold_valid", bus.ifu_req_valid, 1'b1);
            check("req_hold_addr", bus.ifu_req_addr, addr);
            @(negedge clk);
        end
        bus.ifu_req_ready = 1'b1;
        @(negedge clk);
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_inst  = addr ^ 32'h0000_0013;
        @(negedge clk);
        bus.ifu_rsp_valid = 1'b0;
        check("inst_latched", inst, addr ^ 32'h0000_0013);
        if (m && !hlt && !(jmp && tgt[1:0] != 2'b00)) begin
            wait_lsu_valid();
            bus.lsu_req_ready = 1'b1;
            @(negedge clk);
            bus.lsu_req_ready = 1'b0;
            repeat (lsu_dly) @(negedge clk);
            bus.lsu_rsp_valid = 1'b1;
            @(negedge clk);
            bus.lsu_rsp_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic check_quiet(input string name, input logic [31:0] exp_pc);
        logic any_req = 1'b0;
        repeat (20) begin
            @(negedge clk);
            any_req |= bus.ifu_req_valid | bus.lsu_req_valid;
        end
        check({name, "_no_req"}, any_req, 1'b0);
        check({name, "_pc"}, pc, exp_pc);
    endtask

    initial begin
        clear_inputs();
        bus64.ifu_req_ready = 1'b0;
        bus64.ifu_rsp_valid = 1'b0;
        bus64.ifu_rsp_inst  = '0;
        bus64.ifu_rsp_err   = 1'b0;
        bus64.lsu_req_ready = 1'b0;
        bus64.lsu_rsp_valid = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_pc", pc, 32'h8000_0000);
        check("reset_inst", inst, 32'h0);
        check("reset_outputs", {bus.ifu_req_valid, bus.lsu_req_valid, gpr_wen, retire,
                                halted, trap, trap_cause}, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        check("first_fetch_valid", bus.ifu_req_valid, 1'b1);
        check("first_fetch_addr", bus.ifu_req_addr, 32'h8000_0000);

        run_inst(32'h8000_0000, 0, 1, 0, 0, 32'h0, 0, 0, 3, 1);
        run_inst(32'h8000_0004, 0, 1, 0, 0, 32'h0, 5, 0, 8, 1);
        run_inst(32'h8000_0008, 0, 1, 1, 0, 32'h8000_0100, 0, 0, 3, 1);
        run_inst(32'h8000_0100, 0, 0, 0, 0, 32'h0, 0, 0, 3, 1);
        run_inst(32'h8000_0104, 1, 1, 0, 0, 32'h0, 0, 3, 8, 1);
        run_inst(32'h8000_0108, 1, 0, 0, 0, 32'h0, 0, 0, 5, 1);
        run_inst(32'h8000_010C, 0, 1, 1, 0, 32'h8000_0102, 0, 0, 0, 0);
        check("misalign_trap", {trap, trap_cause}, 3'b101);
        check_quiet("misalign", 32'h8000_010C);

        do_reset();
        run_inst(32'h8000_0000, 0, 1, 0, 0, 32'h0, 0, 0, 3, 1);
        run_inst(32'h8000_0004, 0, 1, 0, 1, 32'h0, 0, 0, 3, 1);
        check("halt_retire", {retire, halted, trap}, 3'b110);
        check_quiet("halt", 32'h8000_0004);
        check("halt_sticky", halted, 1'b1);

        do_reset();
        exp_fetch.push_back(32'h8000_0000);
        wait_ifu_valid();
        bus.ifu_req_ready = 1'b1;
        @(negedge clk);
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_err   = 1'b1;
        bus.ifu_rsp_inst  = 32'h0000_0013;
        @(negedge clk);
        bus.ifu_rsp_valid = 1'b0;
        bus.ifu_rsp_err   = 1'b0;
        check("fetch_err_trap", {trap, trap_cause}, 3'b110);
        check("fetch_err_inst", inst, 32'h0);
        check_quiet("fetch_err", 32'h8000_0000);

        do_reset();
        run_inst(32'h8000_0000, 0, 1, 0, 0, 32'h0, 0, 0, 3, 1);
        exp_fetch.push_back(32'h8000_0004);
        {cur_mem, cur_rdw} = 2'b11;
        wait_ifu_valid();
        bus.ifu_req_ready = 1'b1;
        @(negedge clk);
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_inst  = 32'h0000_2003;
        @(negedge clk);
        bus.ifu_rsp_valid = 1'b0;
        wait_lsu_valid();
        bus.lsu_req_ready = 1'b1;
        @(negedge clk);
        bus.lsu_req_ready = 1'b0;
        @(negedge clk);
        check("pre_abort_pc", pc, 32'h8000_0004);
        rst = 1'b0;
        clear_inputs();
        #1;
        check("abort_pc", pc, 32'h8000_0000);
        check("abort_outputs", {bus.ifu_req_valid, bus.lsu_req_valid, retire, gpr_wen}, 4'b0);
        @(negedge clk);
        rst = 1'b1;
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_inst  = 32'hDEAD_BEEF;
        bus.lsu_rsp_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.ifu_rsp_valid = 1'b0;
        bus.lsu_rsp_valid = 1'b0;
        check("stray_inst_ignored", inst, 32'h0);
        check("stray_req_held", {bus.ifu_req_valid, bus.ifu_req_addr}, {1'b1, 32'h8000_0000});
        run_inst(32'h8000_0000, 0, 1, 0, 0, 32'h0, 0, 0, 4, 1);

        @(negedge clk);
        rst64 = 1'b1;
        @(negedge clk);
        check("x64_first_addr", {bus64.ifu_req_valid, bus64.ifu_req_addr}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFC});
        bus64.ifu_req_ready = 1'b1;
        @(negedge clk);
        bus64.ifu_req_ready = 1'b0;
        bus64.ifu_rsp_valid = 1'b1;
        bus64.ifu_rsp_inst  = 32'h0000_0013;
        @(negedge clk);
        bus64.ifu_rsp_valid = 1'b0;
        @(negedge clk);
        check("x64_wb", {gpr_wen64, retire64}, 2'b11);
        @(negedge clk);
        check("x64_wrap_valid", bus64.ifu_req_valid, 1'b1);
        check("x64_wrap_addr", bus64.ifu_req_addr, 64'h0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", {exp_fetch.size(), exp_ret.size()}, 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
